rotary_pos_ctrl: RTL and testbench

//  Multi-channel rotary-joystick position generator for 68000-era rotary-control games (Gang Wars, Ikari-style boards).
//  Per channel: turns cw/ccw button presses into a wrapping position over POSITIONS steps, with auto-repeat while held.

---
 rtl/rotary_pkg.sv | 17 +
 rtl/rotary_channel.sv | 134 +++++++++++++
 rtl/rotary_pos_ctrl.sv | 71 +++++++
 tb/tb_rotary_pos_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared types and helpers for the rotary position controller.
//   rot_state_t : per-channel press/auto-repeat state
//   onehot_of() : binary position -> one-hot decode (callers truncate to POSITIONS bits)
package rotary_pkg;

    typedef enum logic [1:0] {RS_IDLE, RS_HOLD, RS_RPT} rot_state_t;

    // Widest one-hot the decode helper supports; POSITIONS must not exceed this.
    localparam int ROT_MAX_POS = 64;

    function automatic logic [ROT_MAX_POS-1:0] onehot_of(input int unsigned pos);
        logic [ROT_MAX_POS-1:0] one;
        one = {{(ROT_MAX_POS-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

endpackage

// File: rtl/rotary_channel.sv
// One rotary channel: press/reversal detection, hold and auto-repeat timing,
// wrapping position register and its registered one-hot copy.
// Ports:
//   clk_sys, reset  clock, async active-high reset
//   tick            1-cycle timing tick from the shared prescaler
//   repeat_en       auto-repeat enable
//   preset          load strobe; preset_pos is the load value (clamped)
//   cw, ccw         button levels
//   rotary          one-hot position (POSITIONS bits)
//   rotary_pos      binary position
//   step            1-cycle pulse when the position moved
//   restart         press seen this cycle; realigns the shared prescaler
//
// state   | meaning
// RS_IDLE | no valid press being tracked (released, both buttons, preset or reset)
// RS_HOLD | stepped on the press, waiting REPEAT_DELAY ticks for the first repeat
// RS_RPT  | auto-repeating, one step every REPEAT_RATE ticks
module rotary_channel
    import rotary_pkg::*;
#(
    parameter int POSITIONS    = 12,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 60,
    localparam int PW          = $clog2(POSITIONS)
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 repeat_en,
    input  logic                 preset,
    input  logic [PW-1:0]        preset_pos,
    input  logic                 cw,
    input  logic                 ccw,
    output logic [POSITIONS-1:0] rotary,
    output logic [PW-1:0]        rotary_pos,
    output logic                 step,
    output logic                 restart
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);

    rot_state_t           state_q, state_nx;
    logic [PW-1:0]        pos_q, pos_nx;
    logic [POSITIONS-1:0] rot_q;
    logic [CW-1:0]        cnt_q, cnt_nx;
    logic                 step_q, do_step;
    logic                 prev_active_q, prev_cw_q, lock_q;
    logic                 dir_cw, dir_ccw, active, press, tc;

    assign dir_cw  = cw & ~ccw;
    assign dir_ccw = ccw & ~cw;
    assign active  = dir_cw | dir_ccw;

    // lock_q holds off press detection after reset until the buttons have
    // been seen released, so a button held through reset cannot step.
    assign press   = active & ~lock_q & (~prev_active_q | (dir_cw != prev_cw_q));
    assign tc      = tick & (cnt_q == '0);
    assign restart = press & ~preset;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= RS_IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (preset || !active) begin
            state_nx = RS_IDLE;
        end else if (press) begin
            state_nx = RS_HOLD;
        end else begin
            case (state_q)
                RS_HOLD: if (tc && repeat_en) state_nx = RS_RPT;
                default: state_nx = state_q;
            endcase
        end
    end

    // Hold count is a down-counter: loaded on a step, stepped again when a
    // tick arrives with the count already at zero.
    always_comb begin
        do_step = 1'b0;
        cnt_nx  = cnt_q;
        pos_nx  = pos_q;
        if (preset) begin
            pos_nx = (32'(preset_pos) >= POSITIONS) ? PW'(POSITIONS - 1) : preset_pos;
            cnt_nx = '0;
        end else if (active) begin
            if (press) begin
                do_step = 1'b1;
                cnt_nx  = CW'(REPEAT_DELAY - 1);
            end else if (state_q != RS_IDLE && tick) begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - CW'(1);
                end else if (repeat_en) begin
                    do_step = 1'b1;
                    cnt_nx  = CW'(REPEAT_RATE - 1);
                end
            end
            if (do_step) begin
                if (dir_cw)
                    pos_nx = (pos_q == '0) ? PW'(POSITIONS - 1) : pos_q - PW'(1);
                else
                    pos_nx = (pos_q == PW'(POSITIONS - 1)) ? '0 : pos_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pos_q         <= '0;
            rot_q         <= POSITIONS'(1);
            cnt_q         <= '0;
            step_q        <= 1'b0;
            prev_active_q <= 1'b0;
            prev_cw_q     <= 1'b0;
            lock_q        <= 1'b1;
        end else begin
            pos_q         <= pos_nx;
            rot_q         <= POSITIONS'(onehot_of(32'(pos_nx)));
            cnt_q         <= cnt_nx;
            step_q        <= do_step;
            prev_active_q <= active;
            prev_cw_q     <= dir_cw;
            lock_q        <= lock_q & active;
        end
    end

    assign rotary     = rot_q;
    assign rotary_pos = pos_q;
    assign step       = step_q;

endmodule

// File: rtl/rotary_pos_ctrl.sv
// Multi-channel rotary joystick position generator.
// Ports:
//   clk_sys, reset  clock, async active-high reset
//   repeat_en       auto-repeat enable for all channels
//   preset          per-channel load strobe; preset_pos channel n at [n*PW +: PW]
//   cw, ccw         per-channel button levels
//   rotary          one-hot positions; channel n at [n*POSITIONS +: POSITIONS]
//   rotary_pos      binary positions; channel n at [n*PW +: PW]
//   step            per-channel 1-cycle position-change pulse
module rotary_pos_ctrl
    import rotary_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int POSITIONS    = 12,
    parameter int TICK_DIV     = 72000,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 60,
    localparam int PW          = $clog2(POSITIONS)
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          repeat_en,
    input  logic [CHANNELS-1:0]           preset,
    input  logic [CHANNELS*PW-1:0]        preset_pos,
    input  logic [CHANNELS-1:0]           cw,
    input  logic [CHANNELS-1:0]           ccw,
    output logic [CHANNELS*POSITIONS-1:0] rotary,
    output logic [CHANNELS*PW-1:0]        rotary_pos,
    output logic [CHANNELS-1:0]           step
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [CHANNELS-1:0] restart;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // A press on any channel realigns the prescaler so the first repeat
    // lands exactly REPEAT_DELAY ticks after that press. A press on one
    // channel can therefore shift the repeat phase of another by < 1 tick.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)         tick_cnt <= '0;
        else if (|restart) tick_cnt <= '0;
        else if (tick)     tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        rotary_channel #(
            .POSITIONS    (POSITIONS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .tick       (tick),
            .repeat_en  (repeat_en),
            .preset     (preset[n]),
            .preset_pos (preset_pos[n*PW +: PW]),
            .cw         (cw[n]),
            .ccw        (ccw[n]),
            .rotary     (rotary[n*POSITIONS +: POSITIONS]),
            .rotary_pos (rotary_pos[n*PW +: PW]),
            .step       (step[n]),
            .restart    (restart[n])
        );
    end

endmodule

// File: tb/tb_rotary_pos_ctrl.sv
// Scoreboard bench for rotary_pos_ctrl (CHANNELS=2, POSITIONS=12, TICK_DIV=4,
// REPEAT_DELAY=3, REPEAT_RATE=2). Stimulus pushes expected steps (channel,
// position, cycle); the monitor pops one per observed step pulse.
module tb_rotary_pos_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        repeat_en = 1'b0;
    logic [1:0]  preset = '0;
    logic [7:0]  preset_pos = '0;
    logic [1:0]  cw = '0;
    logic [1:0]  ccw = '0;
    logic [23:0] rotary;
    logic [7:0]  rotary_pos;
    logic [1:0]  step;

    always #5 clk_sys = ~clk_sys;

    rotary_pos_ctrl #(
        .CHANNELS(2), .POSITIONS(12), .TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .repeat_en(repeat_en),
        .preset(preset), .preset_pos(preset_pos), .cw(cw), .ccw(ccw),
        .rotary(rotary), .rotary_pos(rotary_pos), .step(step)
    );

    typedef struct {
        int chan;
        int pos;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   m_pos[2];
    int   base;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic int oh(input int p);
        logic [11:0] v;
        v = 12'h001;
        return int'(v << p);
    endfunction

    function automatic int cw_of(input int p);
        return (p == 0) ? 11 : p - 1;
    endfunction

    function automatic int ccw_of(input int p);
        return (p == 11) ? 0 : p + 1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic push(input int ch, input int pos, input int at);
        exp_t e;
        e.chan = ch;
        e.pos  = pos;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    always @(negedge clk_sys) begin
        for (int n = 0; n < 2; n++) begin
            if (step[n]) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_step ch%0d: got step at cycle %0d pos %0d, required no step",
                             n, cyc, rotary_pos[n*4 +: 4]);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("step_chan", n, mon_e.chan);
                    chk("step_cycle", cyc, mon_e.cyc);
                    chk("step_pos", int'(rotary_pos[n*4 +: 4]), mon_e.pos);
                    chk("step_onehot", int'(rotary[n*12 +: 12]), oh(mon_e.pos));
                end
            end
        end
    end

    initial begin
        m_pos[0] = 0;
        m_pos[1] = 0;
        wait_n(3);
        chk("rst_pos0", int'(rotary_pos[3:0]), 0);
        chk("rst_pos1", int'(rotary_pos[7:4]), 0);
        chk("rst_oh0", int'(rotary[11:0]), 12'h001);
        chk("rst_oh1", int'(rotary[23:12]), 12'h001);
        chk("rst_step", int'(step), 0);
        reset = 1'b0;
        wait_n(2);

        // 1: three single cw pulses on ch0
        for (int i = 0; i < 3; i++) begin
            cw[0] = 1'b1;
            m_pos[0] = cw_of(m_pos[0]);
            push(0, m_pos[0], cyc + 1);
            wait_n(1);
            cw[0] = 1'b0;
            wait_n(2);
        end
        chk("t1_pos0", int'(rotary_pos[3:0]), 9);
        chk("t1_oh0", int'(rotary[11:0]), 12'h200);
        chk("t1_pos1", int'(rotary_pos[7:4]), 0);
        chk("t1_oh1", int'(rotary[23:12]), 12'h001);

        // 2: ccw held on ch1 with auto-repeat; wraps 11 -> 0
        repeat_en = 1'b1;
        ccw[1] = 1'b1;
        base = cyc;
        m_pos[1] = ccw_of(m_pos[1]);
        push(1, m_pos[1], base + 1);
        for (int k = 0; k < 11; k++) begin
            m_pos[1] = ccw_of(m_pos[1]);
            push(1, m_pos[1], base + 13 + 8 * k);
        end
        wait_n(94);
        ccw[1] = 1'b0;
        wait_n(3);
        chk("t2_pos1", int'(rotary_pos[7:4]), 0);
        chk("t2_oh1", int'(rotary[23:12]), 12'h001);
        chk("t2_pos0", int'(rotary_pos[3:0]), 9);

        // 3: both buttons high is inactive; releasing ccw steps cw
        cw[0] = 1'b1;
        ccw[0] = 1'b1;
        wait_n(50);
        chk("t3_both_pos0", int'(rotary_pos[3:0]), 9);
        ccw[0] = 1'b0;
        base = cyc;
        m_pos[0] = cw_of(m_pos[0]);
        push(0, m_pos[0], base + 1);
        for (int k = 0; k < 4; k++) begin
            m_pos[0] = cw_of(m_pos[0]);
            push(0, m_pos[0], base + 13 + 8 * k);
        end

        // 4: after 40 cycles of cw, reverse straight to ccw
        wait_n(40);
        chk("t4_pre_rev_pos0", int'(rotary_pos[3:0]), 4);
        cw[0] = 1'b0;
        ccw[0] = 1'b1;
        base = cyc;
        m_pos[0] = ccw_of(m_pos[0]);
        push(0, m_pos[0], base + 1);
        m_pos[0] = ccw_of(m_pos[0]);
        push(0, m_pos[0], base + 13);
        m_pos[0] = ccw_of(m_pos[0]);
        push(0, m_pos[0], base + 21);
        wait_n(24);
        ccw[0] = 1'b0;
        wait_n(3);
        chk("t4_pos0", int'(rotary_pos[3:0]), 7);

        // 5: preset ch0 while auto-repeating, then clamp
        cw[0] = 1'b1;
        base = cyc;
        m_pos[0] = cw_of(m_pos[0]);
        push(0, m_pos[0], base + 1);
        m_pos[0] = cw_of(m_pos[0]);
        push(0, m_pos[0], base + 13);
        wait_n(16);
        preset[0] = 1'b1;
        preset_pos[3:0] = 4'd7;
        wait_n(1);
        preset[0] = 1'b0;
        chk("t5_preset_pos0", int'(rotary_pos[3:0]), 7);
        chk("t5_preset_oh0", int'(rotary[11:0]), 12'h080);
        chk("t5_preset_step0", int'(step[0]), 0);
        wait_n(20);
        chk("t5_idle_pos0", int'(rotary_pos[3:0]), 7);
        preset_pos[3:0] = 4'd14;
        preset[0] = 1'b1;
        wait_n(1);
        preset[0] = 1'b0;
        chk("t5_clamp_pos0", int'(rotary_pos[3:0]), 11);
        chk("t5_clamp_oh0", int'(rotary[11:0]), 12'h800);
        cw[0] = 1'b0;
        wait_n(2);
        m_pos[0] = 11;

        // preset beats a simultaneous press on ch1
        preset[1] = 1'b1;
        preset_pos[7:4] = 4'd3;
        ccw[1] = 1'b1;
        wait_n(1);
        preset[1] = 1'b0;
        chk("t5_prio_pos1", int'(rotary_pos[7:4]), 3);
        chk("t5_prio_step1", int'(step[1]), 0);
        wait_n(20);
        chk("t5_prio_hold_pos1", int'(rotary_pos[7:4]), 3);
        ccw[1] = 1'b0;
        wait_n(2);
        m_pos[1] = 3;

        // 6: reset in the middle of auto-repeat on ch1
        ccw[1] = 1'b1;
        base = cyc;
        m_pos[1] = ccw_of(m_pos[1]);
        push(1, m_pos[1], base + 1);
        m_pos[1] = ccw_of(m_pos[1]);
        push(1, m_pos[1], base + 13);
        wait_n(16);
        reset = 1'b1;
        #1;
        chk("t6_rst_pos", int'(rotary_pos), 0);
        chk("t6_rst_oh", int'(rotary), 24'h001001);
        chk("t6_rst_step", int'(step), 0);
        wait_n(2);
        reset = 1'b0;
        wait_n(30);
        chk("t6_held_pos1", int'(rotary_pos[7:4]), 0);
        ccw[1] = 1'b0;
        wait_n(2);
        ccw[1] = 1'b1;
        push(1, 1, cyc + 1);
        wait_n(1);
        ccw[1] = 1'b0;
        wait_n(2);
        chk("t6_repress_pos1", int'(rotary_pos[7:4]), 1);
        chk("t6_repress_pos0", int'(rotary_pos[3:0]), 0);

        wait_n(5);
        chk("sb_drain_pending", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
